// File: rtl/uart_regs_v2_pkg.sv
// Shared register map for the UART register block: addresses, field
// positions, RX FIFO entry layout and the baud-rate selector type.
package uart_regs_v2_pkg;

    // Register byte addresses
    localparam logic [15:0] ADDR_DATA    = 16'h0004;
    localparam logic [15:0] ADDR_STAT    = 16'h000C;
    localparam logic [15:0] ADDR_CTRL    = 16'h0010;
    localparam logic [15:0] ADDR_LPMODE  = 16'h0014;
    localparam logic [15:0] ADDR_INTSTAT = 16'h0020;
    localparam logic [15:0] ADDR_INTEN   = 16'h0024;
    localparam logic [15:0] ADDR_ID      = 16'h0040;

    // DATA read layout
    localparam int DATA_FERR = 16;
    localparam int DATA_PERR = 17;

    // STAT fields
    localparam int STAT_BUSY      = 2;
    localparam int STAT_RXE       = 4;
    localparam int STAT_TXF       = 8;
    localparam int STAT_RXCNT_LSB = 24;
    localparam int STAT_RXCNT_W   = 8;

    // CTRL fields (BAUD occupies [1:0])
    localparam int CTRL_TXEN = 4;
    localparam int CTRL_RXEN = 5;
    localparam int CTRL_TXST = 6;

    // LPMODE fields (DIV occupies [7:0])
    localparam int LPMODE_EN = 31;

    // INTSTAT bits
    localparam int INTSTAT_TX  = 0;
    localparam int INTSTAT_RX  = 1;
    localparam int INTSTAT_OVF = 2;
    localparam int INT_W       = 3;

    // INTEN fields: enables share INTSTAT bit positions
    localparam int INTEN_TX        = 0;
    localparam int INTEN_RX        = 1;
    localparam int INTEN_OVF       = 2;
    localparam int INTEN_RXTHR_LSB = 8;
    localparam int INTEN_RXTHR_W   = 8;

    // RX FIFO entry: {perr, ferr, data[7:0]}
    localparam int FIFO_ENTRY_W = 10;
    localparam int ENTRY_FERR   = 8;
    localparam int ENTRY_PERR   = 9;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_115200 = 2'd2
    } ctrl_baud_e;

    // Code 3 is not a legal rate; it collapses to the default 9600.
    function automatic ctrl_baud_e baud_sanitize(input logic [1:0] code);
        ctrl_baud_e r;
        case (code)
            2'd1:    r = BAUD_19200;
            2'd2:    r = BAUD_115200;
            default: r = BAUD_9600;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_regs_v2_rx_fifo.sv
// Receive FIFO: power-of-2 depth, occupancy counter, push accepted while
// full when a pop happens in the same cycle; a pop on empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are meaningless until pointers say otherwise.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_regs_v2.sv
// UART register block: bus-facing register file, RX FIFO front end,
// interrupt status/enable logic and registered irq.
//
// Bus handshake: a write is taken on any cycle with wen=1 (no stall);
// each wstrb lane enables its byte. A read request ren=1 is always
// accepted and answered with rvalid=1 on the following cycle; rdata keeps
// its last value whenever rvalid=0.
module uart_regs_v2
    import uart_regs_v2_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 32,
    parameter int          RXFIFO_DEPTH = 8,
    parameter logic [31:0] ID_VALUE     = 32'hCAFE0666
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic                    wen,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    ren,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rx_ferr,
    input  logic                    rx_perr,
    input  logic                    tx_busy,
    input  logic                    tx_full,
    input  logic                    tx_done,
    output logic [1:0]              ctrl_baud,
    output logic                    ctrl_txen,
    output logic                    ctrl_rxen,
    output logic                    ctrl_txst,
    output logic [7:0]              lp_div,
    output logic                    lp_en,
    output logic                    irq
);

    localparam int CNT_W = $clog2(RXFIFO_DEPTH) + 1;

    // Register state
    ctrl_baud_e                 baud_q;
    logic                       txen_q;
    logic                       rxen_q;
    logic                       txst_q;
    logic [7:0]                 lp_div_q;
    logic                       lp_en_q;
    logic [INT_W-1:0]           intstat_q;
    logic [INT_W-1:0]           inten_q;
    logic [INTEN_RXTHR_W-1:0]   rxthr_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       rvalid_q;
    logic                       irq_q;

    // Decode and datapath
    logic                       wr_ctrl;
    logic                       wr_lpmode;
    logic                       wr_intstat;
    logic                       wr_inten;
    logic                       rd_data_hit;
    logic [FIFO_ENTRY_W-1:0]    fifo_din;
    logic [FIFO_ENTRY_W-1:0]    fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_drop;
    logic                       rx_push;
    logic                       rx_level_hit;
    logic [INT_W-1:0]           int_set;
    logic [INT_W-1:0]           int_clr;
    logic [INT_W-1:0]           intstat_d;
    logic [31:0]                rd_word;
    logic                       unused_bits;

    assign wr_ctrl     = wen && (waddr == ADDR_WIDTH'(ADDR_CTRL));
    assign wr_lpmode   = wen && (waddr == ADDR_WIDTH'(ADDR_LPMODE));
    assign wr_intstat  = wen && (waddr == ADDR_WIDTH'(ADDR_INTSTAT));
    assign wr_inten    = wen && (waddr == ADDR_WIDTH'(ADDR_INTEN));
    assign rd_data_hit = ren && (raddr == ADDR_WIDTH'(ADDR_DATA));

    // Receiver pushes are only honoured while the receiver is enabled.
    assign rx_push  = rx_valid && rxen_q;
    assign fifo_din = {rx_perr, rx_ferr, rx_data};

    uart_rx_fifo #(
        .DEPTH (RXFIFO_DEPTH),
        .WIDTH (FIFO_ENTRY_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rd_data_hit),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    // RX level interrupt is a level condition; threshold 0 disables it.
    assign rx_level_hit = (rxthr_q != '0) && (32'(fifo_count) >= 32'(rxthr_q));

    // Interrupt status next state: write-1-to-clear, hardware set has priority.
    always_comb begin
        int_set              = '0;
        int_set[INTSTAT_TX]  = tx_done;
        int_set[INTSTAT_RX]  = rx_level_hit;
        int_set[INTSTAT_OVF] = fifo_drop;
        int_clr              = '0;
        if (wr_intstat && wstrb[0]) begin
            int_clr = wdata[INT_W-1:0];
        end
        intstat_d = (intstat_q & ~int_clr) | int_set;
    end

    // Read mux: unmapped addresses return zero.
    always_comb begin
        rd_word = '0;
        case (raddr)
            ADDR_WIDTH'(ADDR_DATA): begin
                if (!fifo_empty) begin
                    rd_word[7:0]      = fifo_dout[7:0];
                    rd_word[DATA_FERR] = fifo_dout[ENTRY_FERR];
                    rd_word[DATA_PERR] = fifo_dout[ENTRY_PERR];
                end
            end
            ADDR_WIDTH'(ADDR_STAT): begin
                rd_word[STAT_BUSY] = tx_busy;
                rd_word[STAT_RXE]  = fifo_empty;
                rd_word[STAT_TXF]  = tx_full;
                rd_word[STAT_RXCNT_LSB +: STAT_RXCNT_W] = STAT_RXCNT_W'(fifo_count);
            end
            ADDR_WIDTH'(ADDR_CTRL): begin
                rd_word[1:0]       = baud_q;
                rd_word[CTRL_TXEN] = txen_q;
                rd_word[CTRL_RXEN] = rxen_q;
            end
            ADDR_WIDTH'(ADDR_LPMODE): begin
                rd_word[7:0]       = lp_div_q;
                rd_word[LPMODE_EN] = lp_en_q;
            end
            ADDR_WIDTH'(ADDR_INTSTAT): begin
                rd_word[INT_W-1:0] = intstat_q;
            end
            ADDR_WIDTH'(ADDR_INTEN): begin
                rd_word[INT_W-1:0] = inten_q;
                rd_word[INTEN_RXTHR_LSB +: INTEN_RXTHR_W] = rxthr_q;
            end
            ADDR_WIDTH'(ADDR_ID): begin
                rd_word = ID_VALUE;
            end
            default: rd_word = '0;
        endcase
    end

    // Control, low-power and interrupt registers with byte-lane writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q    <= BAUD_9600;
            txen_q    <= 1'b0;
            rxen_q    <= 1'b0;
            txst_q    <= 1'b0;
            lp_div_q  <= '0;
            lp_en_q   <= 1'b0;
            intstat_q <= '0;
            inten_q   <= '0;
            rxthr_q   <= '0;
        end else begin
            txst_q    <= wr_ctrl && wstrb[0] && wdata[CTRL_TXST];
            intstat_q <= intstat_d;
            if (wr_ctrl && wstrb[0]) begin
                baud_q <= baud_sanitize(wdata[1:0]);
                txen_q <= wdata[CTRL_TXEN];
                rxen_q <= wdata[CTRL_RXEN];
            end
            if (wr_lpmode && wstrb[0]) begin
                lp_div_q <= wdata[7:0];
            end
            if (wr_lpmode && wstrb[3]) begin
                lp_en_q <= wdata[LPMODE_EN];
            end
            if (wr_inten && wstrb[0]) begin
                inten_q <= wdata[INT_W-1:0];
            end
            if (wr_inten && wstrb[1]) begin
                rxthr_q <= wdata[INTEN_RXTHR_LSB +: INTEN_RXTHR_W];
            end
        end
    end

    // Read response: one-cycle latency, rdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ren;
            if (ren) begin
                rdata_q <= DATA_WIDTH'(rd_word);
            end
        end
    end

    // irq follows the registered status one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(intstat_q & inten_q);
        end
    end

    assign unused_bits = ^{wdata, wstrb};

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign ctrl_baud = baud_q;
    assign ctrl_txen = txen_q;
    assign ctrl_rxen = rxen_q;
    assign ctrl_txst = txst_q;
    assign lp_div    = lp_div_q;
    assign lp_en     = lp_en_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_regs_v2.sv
// Bench for uart_regs_v2: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model of the register map.
module tb_uart_regs_v2;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] waddr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [15:0] raddr = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ferr = 1'b0;
    logic        rx_perr = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_full = 1'b0;
    logic        tx_done = 1'b0;
    logic [1:0]  ctrl_baud;
    logic        ctrl_txen;
    logic        ctrl_rxen;
    logic        ctrl_txst;
    logic [7:0]  lp_div;
    logic        lp_en;
    logic        irq;

    uart_regs_v2 #(
        .ADDR_WIDTH   (16),
        .DATA_WIDTH   (32),
        .RXFIFO_DEPTH (DEPTH),
        .ID_VALUE     (32'hCAFE0666)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .waddr     (waddr),
        .wen       (wen),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ferr   (rx_ferr),
        .rx_perr   (rx_perr),
        .tx_busy   (tx_busy),
        .tx_full   (tx_full),
        .tx_done   (tx_done),
        .ctrl_baud (ctrl_baud),
        .ctrl_txen (ctrl_txen),
        .ctrl_rxen (ctrl_rxen),
        .ctrl_txst (ctrl_txst),
        .lp_div    (lp_div),
        .lp_en     (lp_en),
        .irq       (irq)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [9:0]  m_q[$];
    logic [1:0]  m_baud;
    logic        m_txen, m_rxen, m_txst, m_lpen, m_irq;
    logic [7:0]  m_lpdiv, m_rxthr;
    logic [2:0]  m_ists, m_ien;
    logic [31:0] m_rdata;
    logic [15:0] addr_tab[10] = '{16'h04, 16'h0C, 16'h10, 16'h14, 16'h20,
                                  16'h24, 16'h40, 16'h08, 16'h44, 16'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return 32'({ctrl_baud, ctrl_txen, ctrl_rxen, ctrl_txst, lp_div, lp_en, irq});
    endfunction

    function automatic logic [31:0] model_outs();
        return 32'({m_baud, m_txen, m_rxen, m_txst, m_lpdiv, m_lpen, m_irq});
    endfunction

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_baud = 0; m_txen = 0; m_rxen = 0; m_txst = 0; m_lpen = 0; m_irq = 0;
        m_lpdiv = 0; m_rxthr = 0; m_ists = 0; m_ien = 0; m_rdata = 0;
    endtask

    // What a read of address a returns given the register map contents.
    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            16'h04: if (m_q.size() > 0) begin
                v[7:0] = m_q[0][7:0];
                v[16]  = m_q[0][8];
                v[17]  = m_q[0][9];
            end
            16'h0C: begin
                v[2]     = tx_busy;
                v[4]     = (m_q.size() == 0);
                v[8]     = tx_full;
                v[31:24] = 8'(m_q.size());
            end
            16'h10: v = 32'(m_baud) | (32'(m_txen) << 4) | (32'(m_rxen) << 5);
            16'h14: v = 32'(m_lpdiv) | (32'(m_lpen) << 31);
            16'h20: v = 32'(m_ists);
            16'h24: v = 32'(m_ien) | (32'(m_rxthr) << 8);
            16'h40: v = 32'hCAFE0666;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        wen = 0; ren = 0; rx_valid = 0; tx_done = 0; wstrb = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare DUT outputs just after the edge.
    task automatic step();
        int         sz;
        bit         popped;
        logic [2:0] setb, clrb;
        logic       nirq;
        sz = m_q.size();
        if (ren) exp_q.push_back(model_read(raddr));
        nirq = |(m_ists & m_ien);
        popped = 0;
        if (ren && raddr == 16'h04 && sz > 0) begin
            void'(m_q.pop_front());
            popped = 1;
        end
        setb = 0;
        clrb = 0;
        if (rx_valid && m_rxen) begin
            if (sz < DEPTH || popped) m_q.push_back({rx_perr, rx_ferr, rx_data});
            else setb[2] = 1;
        end
        setb[0] = tx_done;
        setb[1] = (m_rxthr != 0) && (sz >= int'(m_rxthr));
        m_txst = 0;
        if (wen) begin
            case (waddr)
                16'h10: if (wstrb[0]) begin
                    m_baud = (wdata[1:0] == 2'd3) ? 2'd0 : wdata[1:0];
                    m_txen = wdata[4];
                    m_rxen = wdata[5];
                    m_txst = wdata[6];
                end
                16'h14: begin
                    if (wstrb[0]) m_lpdiv = wdata[7:0];
                    if (wstrb[3]) m_lpen = wdata[31];
                end
                16'h20: if (wstrb[0]) clrb = wdata[2:0];
                16'h24: begin
                    if (wstrb[0]) m_ien = wdata[2:0];
                    if (wstrb[1]) m_rxthr = wdata[15:8];
                end
                default: ;
            endcase
        end
        m_ists = (m_ists & ~clrb) | setb;
        m_irq = nirq;
        @(posedge clk);
        #1;
        if (ren) begin
            check("rvalid", 32'(rvalid), 32'd1);
            m_rdata = exp_q.pop_front();
            check("rdata", rdata, m_rdata);
        end else begin
            check("rvalid_idle", 32'(rvalid), 32'd0);
            check("rdata_hold", rdata, m_rdata);
        end
        check("outs", dut_outs(), model_outs());
        idle();
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1; waddr = a; wdata = d; wstrb = s;
        step();
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        ren = 1; raddr = a;
        step();
        d = rdata;
    endtask

    task automatic push(input logic [7:0] b, input logic fe, input logic pe);
        rx_valid = 1; rx_data = b; rx_ferr = fe; rx_perr = pe;
        step();
    endtask

    // Assert reset between clock edges and check the asynchronous clear.
    task automatic do_reset();
        #3 rst = 1;
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_outs", dut_outs(), 32'd0);
        model_reset();
        idle();
        tx_busy = 0;
        tx_full = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        do_reset();

        // reset values
        rd(16'h40, d);  check("id", d, 32'hCAFE0666);
        rd(16'h10, d);  check("ctrl_reset", d, 32'h0);
        check("outs_reset", dut_outs(), 32'h0);

        // FIFO push/pop with error flags
        wr(16'h10, 32'h20, 4'b0001);
        push(8'h41, 1'b1, 1'b0);
        push(8'h42, 1'b0, 1'b0);
        rd(16'h04, d);  check("data0", d, 32'h00010041);
        rd(16'h04, d);  check("data1", d, 32'h00000042);
        rd(16'h04, d);  check("data_empty", d, 32'h0);
        rd(16'h0C, d);  check("stat_rxe", d & 32'h10, 32'h10);

        // overflow and interrupt
        wr(16'h24, 32'h4, 4'b0001);
        for (int i = 0; i < 9; i++) push(8'(i), 1'b0, 1'b0);
        rd(16'h0C, d);  check("rxcnt_full", d >> 24, 32'd8);
        check("irq_ovf", 32'(irq), 32'd1);
        rd(16'h20, d);  check("ovf_set", d & 32'h4, 32'h4);
        wr(16'h20, 32'h4, 4'b0001);
        step();
        check("irq_clear", 32'(irq), 32'd0);
        rd(16'h20, d);  check("ovf_clear", d & 32'h4, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(16'h04, d);
            check("drain", d, 32'(i));
        end

        // tx_done beats a same-cycle clear
        tx_done = 1; step();
        tx_done = 1; wr(16'h20, 32'h1, 4'b0001);
        rd(16'h20, d);  check("tx_set_wins", d & 32'h1, 32'h1);
        wr(16'h20, 32'h1, 4'b0001);
        rd(16'h20, d);  check("tx_w1c", d & 32'h1, 32'h0);

        // LPMODE byte lanes
        wr(16'h14, 32'hFFFF_FFFF, 4'b0001);
        check("lp_div", 32'(lp_div), 32'hFF);
        check("lp_en0", 32'(lp_en), 32'd0);
        wr(16'h14, 32'h8000_0000, 4'b1000);
        check("lp_en1", 32'(lp_en), 32'd1);

        // TXST pulse and illegal baud code
        wr(16'h10, 32'h01, 4'b0001);
        check("baud1", 32'(ctrl_baud), 32'd1);
        wr(16'h10, 32'h43, 4'b0001);
        check("txst_hi", 32'(ctrl_txst), 32'd1);
        check("baud3", 32'(ctrl_baud), 32'd0);
        check("txen_rxen", 32'({ctrl_txen, ctrl_rxen}), 32'd0);
        step();
        check("txst_lo", 32'(ctrl_txst), 32'd0);
        rd(16'h10, d);  check("ctrl_rd", d, 32'h0);

        // randomized traffic against the model
        wr(16'h10, 32'h30, 4'b0001);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wen   = 1;
                waddr = addr_tab[$urandom_range(0, 9)];
                wdata = $urandom();
                wstrb = 4'($urandom_range(0, 15));
                if (waddr == 16'h10 && $urandom_range(0, 3) != 0) wdata[5] = 1'b1;
                if (waddr == 16'h24) wdata[15:8] = 8'($urandom_range(0, 9));
            end
            ren   = ($urandom_range(0, 1) == 0);
            raddr = ($urandom_range(0, 1) == 0) ? 16'h04 : addr_tab[$urandom_range(0, 9)];
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom());
            rx_ferr  = 1'($urandom());
            rx_perr  = 1'($urandom());
            tx_done  = ($urandom_range(0, 9) == 0);
            tx_busy  = 1'($urandom());
            tx_full  = 1'($urandom());
            step();
        end

        // reset in the middle of a read with data pending
        wr(16'h10, 32'h31, 4'b0001);
        wr(16'h24, 32'h7, 4'b0001);
        push(8'h5A, 1'b0, 1'b1);
        push(8'h5B, 1'b0, 1'b0);
        rd(16'h40, d);
        ren = 1; raddr = 16'h04; rx_valid = 1; rx_data = 8'h77;
        do_reset();
        rd(16'h0C, d);  check("stat_after_rst", d, 32'h10);
        rd(16'h04, d);  check("data_after_rst", d, 32'h0);
        rd(16'h10, d);  check("ctrl_after_rst", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
